// File: rtl/uart_msg_pkg.sv
// Shared constants, error codes, parser state encodings and sizing helpers
// for the streaming UART message parser.
package uart_msg_pkg;

    localparam logic [7:0] ASCII_LBRACE = 8'h7B;
    localparam logic [7:0] ASCII_RBRACE = 8'h7D;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_9      = 8'h39;

    typedef enum logic [1:0] {
        ERR_CHAR    = 2'd0,
        ERR_RANGE   = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_OVF     = 2'd3
    } err_code_t;

    // Parser state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TAG   = 2'd1;
    localparam logic [1:0] ST_DIGIT = 2'd2;
    localparam logic [1:0] ST_SEP   = 2'd3;

    // Bits needed to hold values 0..n-1 (never less than 1)
    function automatic int clog2(input longint unsigned n);
        longint unsigned v;
        int r;
        v = 1;
        r = 0;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned v;
        v = 1;
        for (int unsigned i = 0; i < n; i++) v = v * 10;
        return v;
    endfunction

endpackage

// File: rtl/dec_field_acc.sv
// Fixed-length decimal accumulator for one message field. done_o, range_err_o
// and val_o describe the digit being presented this cycle, so the parser can
// act on the final digit without an extra cycle of latency.
module dec_field_acc
    import uart_msg_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int VAL_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             dig_vld_i,
    input  logic [3:0]       dig_i,
    output logic             done_o,
    output logic             range_err_o,
    output logic [VAL_W-1:0] val_o
);

    localparam int ACC_W = clog2(pow10(DIGITS));
    localparam int CNT_W = clog2(longint'(DIGITS + 1));
    localparam logic [63:0] VAL_MAX = (64'd1 << VAL_W) - 64'd1;

    logic [ACC_W-1:0] acc_q, acc_d, acc_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign acc_next    = ACC_W'(acc_q * ACC_W'(10)) + ACC_W'(dig_i);
    assign done_o      = dig_vld_i && (cnt_q == CNT_W'(DIGITS - 1));
    assign range_err_o = done_o && (64'(acc_next) > VAL_MAX);
    assign val_o       = VAL_W'(acc_next);

    // Next accumulator/digit count: clear at field start, fold in each digit
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (dig_vld_i) begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_msg_parser_n.sv
// Streaming parser for framed ASCII messages "{T0ddd,T1ddd,...}" arriving one
// byte per rx_done strobe. Parsed fields are staged, then committed into a
// one-entry valid/ready holding register on the closing brace.
module uart_msg_parser_n
    import uart_msg_pkg::*;
#(
    parameter int                      NUM_FIELDS     = 3,
    parameter int                      DIGITS         = 3,
    parameter int                      VAL_W          = 8,
    parameter logic [NUM_FIELDS*8-1:0] FIELD_TAGS     = "RCV",
    parameter int                      TIMEOUT_CYCLES = 34722
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx_en,
    input  logic [7:0]                  rx_byte,
    input  logic                        rx_done,
    output logic [NUM_FIELDS*VAL_W-1:0] out_fields,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        err_pulse,
    output logic [1:0]                  err_code,
    output logic [15:0]                 err_count,
    output logic                        busy
);

    localparam int KW = clog2(longint'(NUM_FIELDS));
    localparam int TW = clog2(longint'(TIMEOUT_CYCLES) + 1);

    logic [1:0]                  state_q, state_d;
    logic [KW-1:0]               k_q, k_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic [NUM_FIELDS*VAL_W-1:0] staging_q, staging_d;
    logic [NUM_FIELDS*VAL_W-1:0] out_fields_q;
    logic                        out_valid_q;
    logic                        err_pulse_q;
    err_code_t                   err_code_q;
    logic [15:0]                 err_count_q;

    logic             acc_clr, dig_vld, acc_done, acc_range;
    logic [VAL_W-1:0] acc_val;
    logic [7:0]       tag_cur;
    logic             is_digit, last_field, commit, ovf, fsm_err, err_any;
    err_code_t        fsm_code, err_code_d;

    dec_field_acc #(
        .DIGITS (DIGITS),
        .VAL_W  (VAL_W)
    ) u_acc (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (acc_clr),
        .dig_vld_i   (dig_vld),
        .dig_i       (rx_byte[3:0]),
        .done_o      (acc_done),
        .range_err_o (acc_range),
        .val_o       (acc_val)
    );

    assign is_digit   = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);
    assign last_field = (k_q == KW'(NUM_FIELDS - 1));

    // Tag letter expected for the current field index
    always_comb begin
        tag_cur = '0;
        for (int unsigned f = 0; f < NUM_FIELDS; f++)
            if (k_q == KW'(f)) tag_cur = FIELD_TAGS[8*(NUM_FIELDS-1-f) +: 8];
    end

    // Parser FSM, inter-byte timer and staging update
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        timer_d   = timer_q;
        staging_d = staging_q;
        acc_clr   = 1'b0;
        dig_vld   = 1'b0;
        commit    = 1'b0;
        fsm_err   = 1'b0;
        fsm_code  = ERR_CHAR;
        if (!rx_en) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else if (rx_done) begin
            timer_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == ASCII_LBRACE) begin
                        state_d = ST_TAG;
                        k_d     = '0;
                    end
                end
                ST_TAG: begin
                    if (rx_byte == tag_cur) begin
                        state_d = ST_DIGIT;
                        acc_clr = 1'b1;
                    end else begin
                        fsm_err = 1'b1;
                    end
                end
                ST_DIGIT: begin
                    if (is_digit) begin
                        dig_vld = 1'b1;
                        if (acc_done) begin
                            if (acc_range) begin
                                fsm_err  = 1'b1;
                                fsm_code = ERR_RANGE;
                            end else begin
                                for (int unsigned f = 0; f < NUM_FIELDS; f++)
                                    if (k_q == KW'(f))
                                        staging_d[VAL_W*(NUM_FIELDS-1-f) +: VAL_W] = acc_val;
                                state_d = ST_SEP;
                            end
                        end
                    end else begin
                        fsm_err = 1'b1;
                    end
                end
                default: begin
                    if (last_field && rx_byte == ASCII_RBRACE) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (!last_field && rx_byte == ASCII_COMMA) begin
                        state_d = ST_TAG;
                        k_d     = k_q + KW'(1);
                    end else begin
                        fsm_err = 1'b1;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                fsm_err  = 1'b1;
                fsm_code = ERR_TIMEOUT;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
        // An offending '{' is treated as the start of a fresh message
        if (fsm_err) begin
            staging_d = '0;
            timer_d   = '0;
            if (fsm_code == ERR_CHAR && rx_byte == ASCII_LBRACE) begin
                state_d = ST_TAG;
                k_d     = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    assign ovf        = commit && out_valid_q && !out_ready;
    assign err_any    = fsm_err || ovf;
    assign err_code_d = ovf ? ERR_OVF : fsm_code;

    // Parser state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            timer_q   <= '0;
            staging_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            timer_q   <= timer_d;
            staging_q <= staging_d;
        end
    end

    // One-entry holding register; a commit with a full, stalled slot is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            out_fields_q <= '0;
            out_valid_q  <= 1'b0;
        end else if (commit && !ovf) begin
            out_fields_q <= staging_q;
            out_valid_q  <= 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    // Error strobe, sticky code and saturating counter
    always_ff @(posedge clk) begin
        if (reset) begin
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_CHAR;
            err_count_q <= '0;
        end else begin
            err_pulse_q <= err_any;
            if (err_any) begin
                err_code_q <= err_code_d;
                if (err_count_q != '1) err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign out_fields = out_fields_q;
    assign out_valid  = out_valid_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;
    assign err_count  = err_count_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_msg_parser_n.sv
// Bench for uart_msg_parser_n: a message-position model checks the default
// instance every cycle; a 4-field instance is checked with literal values.
module tb_uart_msg_parser_n;

    localparam int T = 34722;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default instance
    logic        rx_en, rx_done, out_ready;
    logic [7:0]  rx_byte;
    logic [23:0] out_fields;
    logic        out_valid, err_pulse, busy;
    logic [1:0]  err_code;
    logic [15:0] err_count;

    // Wide instance
    logic        rx_en2, rx_done2, out_ready2;
    logic [7:0]  rx_byte2;
    logic [47:0] out_fields2;
    logic        out_valid2, err_pulse2, busy2;
    logic [1:0]  err_code2;
    logic [15:0] err_count2;

    uart_msg_parser_n dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .rx_byte(rx_byte), .rx_done(rx_done),
        .out_fields(out_fields), .out_valid(out_valid), .out_ready(out_ready),
        .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count), .busy(busy)
    );

    uart_msg_parser_n #(
        .NUM_FIELDS(4), .DIGITS(4), .VAL_W(12), .FIELD_TAGS("RCVX")
    ) dut2 (
        .clk(clk), .reset(reset), .rx_en(rx_en2), .rx_byte(rx_byte2), .rx_done(rx_done2),
        .out_fields(out_fields2), .out_valid(out_valid2), .out_ready(out_ready2),
        .err_pulse(err_pulse2), .err_code(err_code2), .err_count(err_count2), .busy(busy2)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- message-position model of the default instance ----------
    // pos = index of the next expected character within "{Rddd,Cddd,Vddd}",
    // or -1 when no message is open.
    byte         tags[3] = '{"R", "C", "V"};
    int          pos, gap, m_count;
    int          vals[3];
    logic [23:0] m_fields;
    bit          m_valid, m_pulse;
    logic [1:0]  m_code;

    always @(posedge clk) begin : model
        int f, off;
        bit ok, commit, e, rng;
        int ecode;
        commit = 0; e = 0; rng = 0; ecode = 0;
        if (reset) begin
            pos = -1; gap = 0; m_fields = '0; m_valid = 0;
            m_pulse = 0; m_code = '0; m_count = 0;
        end else begin
            m_pulse = 0;
            if (!rx_en) begin
                pos = -1; gap = 0;
            end else if (rx_done) begin
                gap = 0;
                if (pos < 0) begin
                    if (rx_byte == "{") pos = 1;
                end else begin
                    f   = (pos - 1) / 5;
                    off = (pos - 1) % 5;
                    if (off == 0) begin
                        ok = (rx_byte == tags[f]);
                        vals[f] = 0;
                    end else if (off <= 3) begin
                        ok = (rx_byte >= "0" && rx_byte <= "9");
                        if (ok) begin
                            vals[f] = vals[f] * 10 + int'(rx_byte) - 48;
                            if (off == 3 && vals[f] > 255) rng = 1;
                        end
                    end else begin
                        ok = (rx_byte == ((f < 2) ? 8'h2C : 8'h7D));
                        if (ok && f == 2) commit = 1;
                    end
                    if (rng) begin
                        e = 1; ecode = 1; pos = -1;
                    end else if (!ok) begin
                        e = 1; ecode = 0;
                        pos = (rx_byte == "{") ? 1 : -1;
                    end else if (commit) begin
                        pos = -1;
                    end else begin
                        pos++;
                    end
                end
            end else if (pos >= 0) begin
                gap++;
                if (gap == T) begin
                    e = 1; ecode = 2; pos = -1; gap = 0;
                end
            end
            if (commit) begin
                if (m_valid && !out_ready) begin
                    e = 1; ecode = 3;
                end else begin
                    m_fields = {vals[0][7:0], vals[1][7:0], vals[2][7:0]};
                    m_valid  = 1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (e) begin
                m_pulse = 1;
                m_code  = 2'(ecode);
                if (m_count < 65535) m_count++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("err_pulse", 64'(err_pulse), 64'(m_pulse));
            chk("err_code",  64'(err_code),  64'(m_code));
            chk("err_count", 64'(err_count), 64'(m_count));
            chk("busy",      64'(busy),      64'(pos >= 0));
            if (m_valid) chk("out_fields", 64'(out_fields), 64'(m_fields));
        end
    end

    // ---------------- stimulus ------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input byte b);
        rx_byte = b; rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_byte2(input byte b);
        rx_byte2 = b; rx_done2 = 1'b1;
        tick();
        rx_done2 = 1'b0;
        tick();
    endtask

    task automatic send_str2(input string s);
        for (int i = 0; i < s.len(); i++) send_byte2(s[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        rx_en = 1'b1; rx_done = 1'b0; rx_byte = '0; out_ready = 1'b1;
        rx_en2 = 1'b1; rx_done2 = 1'b0; rx_byte2 = '0; out_ready2 = 1'b1;
        reset = 1'b1;
        tick(); tick();
        chk("rst_fields", 64'(out_fields), 64'h0);
        chk("rst_valid",  64'(out_valid),  64'h0);
        chk("rst_count",  64'(err_count),  64'h0);
        chk("rst_busy",   64'(busy),       64'h0);
        reset = 1'b0;
        tick();

        // Plain message
        send_str("{R007,C001,V005}");
        chk("m1_fields", 64'(out_fields), 64'h070105);
        chk("m1_count",  64'(err_count),  64'h0);

        // Missing comma, then full-scale values
        send_str("{R126C200V255}");
        chk("nocomma_code",  64'(err_code),  64'h0);
        chk("nocomma_count", 64'(err_count), 64'h1);
        send_str("{R255,C255,V255}");
        chk("max_fields", 64'(out_fields), 64'hFFFFFF);

        // Range error on first field
        do_reset();
        send_str("{R256,C000,V000}");
        chk("range_code",   64'(err_code),   64'h1);
        chk("range_count",  64'(err_count),  64'h1);
        chk("range_fields", 64'(out_fields), 64'h0);

        // Overflow with a stalled consumer
        do_reset();
        out_ready = 1'b0;
        send_str("{R001,C002,V003}");
        send_str("{R004,C005,V006}");
        chk("ovf_code",   64'(err_code),   64'h3);
        chk("ovf_count",  64'(err_count),  64'h1);
        chk("ovf_valid",  64'(out_valid),  64'h1);
        chk("ovf_fields", 64'(out_fields), 64'h010203);
        // rx_en drop mid-message leaves the held entry alone
        send_str("{R1");
        chk("en_busy_before", 64'(busy), 64'h1);
        rx_en = 1'b0;
        tick();
        rx_en = 1'b1;
        chk("en_busy_after", 64'(busy),      64'h0);
        chk("en_valid",      64'(out_valid), 64'h1);
        chk("en_count",      64'(err_count), 64'h1);
        out_ready = 1'b1;
        tick();
        chk("drain_valid", 64'(out_valid), 64'h0);

        // Timeout, then resync on a stray '{'
        do_reset();
        send_str("{R01");
        repeat (T + 5) tick();
        chk("tmo_code",  64'(err_code),  64'h2);
        chk("tmo_busy",  64'(busy),      64'h0);
        chk("tmo_count", 64'(err_count), 64'h1);
        send_str("{R0{R001,C002,V003}");
        chk("resync_fields", 64'(out_fields), 64'h010203);
        chk("resync_code",   64'(err_code),   64'h0);
        chk("resync_count",  64'(err_count),  64'h2);

        // Four 4-digit 12-bit fields
        do_reset();
        send_str2("{R4095,C0001,V0002,X0100}");
        chk("w_fields", out_fields2, 64'hFFF001002064);
        chk("w_count",  64'(err_count2), 64'h0);
        send_str2("{R12");
        chk("w_busy_before", 64'(busy2), 64'h1);
        rx_en2 = 1'b0;
        tick();
        rx_en2 = 1'b1;
        chk("w_busy_after", 64'(busy2),      64'h0);
        chk("w_count2",     64'(err_count2), 64'h0);
        send_str2("{R4096,C0000,V0000,X0000}");
        chk("w_range_code",  64'(err_code2),  64'h1);
        chk("w_range_count", 64'(err_count2), 64'h1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
